// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// slot phase encoding, the hex segment table and its decode function.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_ON    = 2'd1,
        PH_OFF   = 2'd2
    } phase_e;

    // Active-high patterns {dp,g,f,e,d,c,b,a}; entry n sits at bits [8n+7:8n].
    localparam logic [16*8-1:0] SEG7_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    localparam logic [7:0] SEG_OFF_ACTIVE_HIGH = 8'h00;
    localparam logic [7:0] SEG_OFF_ACTIVE_LOW  = 8'hFF;
    localparam logic [7:0] SEG_DP_ONLY         = 8'h80;

    function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
        return SEG7_TABLE[{nib, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot/digit counters for the scanner, plus the slot phase and frame snapshot strobe.
// Phase and strobe are combinational from the counter registers.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int SCAN_DIV  = 64,
    parameter int BLANK_CYC = 16,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       brightness_i,
    output logic [IDX_W-1:0] idx_o,
    output phase_e           phase_o,
    output logic             snap_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int WIN   = (SCAN_DIV - BLANK_CYC) / 16;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      rel;
    logic [31:0]      on_len;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // On-window is (brightness+1) sixteenths of the post-blank part of the slot.
    always_comb begin
        rel     = 32'(cnt_q) - 32'(BLANK_CYC);
        on_len  = (32'(brightness_i) + 32'd1) * 32'(WIN);
        phase_o = PH_OFF;
        if (32'(cnt_q) < 32'(BLANK_CYC)) begin
            phase_o = PH_BLANK;
        end else if (rel < on_len) begin
            phase_o = PH_ON;
        end
    end

    assign idx_o  = idx_q;
    assign snap_o = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment driver: per-frame input snapshot, hex decode, leading-zero
// blanking, anti-ghost blank window and brightness PWM; all pin outputs registered.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 64,
    parameter int BLANK_CYC      = 16,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] number,
    input  logic [DIGITS-1:0]   dp,
    input  logic                lzs,
    input  logic [3:0]          brightness,
    input  logic                en,
    output logic [7:0]          seg_leds,
    output logic [DIGITS-1:0]   seg_nCS,
    output logic                frame_start
);

    localparam int         IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] SEG_POL = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_ACTIVE_LOW
                                                           : SEG_OFF_ACTIVE_HIGH;

    logic [IDX_W-1:0]    idx;
    phase_e              phase;
    logic                snap;

    logic [4*DIGITS-1:0] number_q;
    logic [DIGITS-1:0]   dp_q;
    logic                lzs_q;
    logic [3:0]          bright_q;

    logic [4*DIGITS-1:0] number_eff;
    logic [DIGITS-1:0]   dp_eff;
    logic                lzs_eff;
    logic [3:0]          bright_eff;

    logic [DIGITS-1:0]   blank_mask;
    logic                zero_tail;
    logic [3:0]          nib;
    logic                dp_cur;
    logic                blank_cur;
    logic                show;
    logic [7:0]          seg_ah;

    logic [7:0]          seg_leds_q, seg_leds_d;
    logic [DIGITS-1:0]   seg_ncs_q, seg_ncs_d;
    logic                frame_start_q;

    // In the snapshot cycle the live inputs are used, so slot 0 never shows last frame's data.
    assign number_eff = snap ? number     : number_q;
    assign dp_eff     = snap ? dp         : dp_q;
    assign lzs_eff    = snap ? lzs        : lzs_q;
    assign bright_eff = snap ? brightness : bright_q;

    seg_scan_timer #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .IDX_W     (IDX_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .brightness_i (bright_eff),
        .idx_o        (idx),
        .phase_o      (phase),
        .snap_o       (snap)
    );

    always_comb begin
        zero_tail  = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_tail     = zero_tail && (number_eff[4*i +: 4] == 4'h0);
            blank_mask[i] = lzs_eff && zero_tail && (i != 0);
        end
    end

    assign nib       = number_eff[{idx, 2'b00} +: 4];
    assign dp_cur    = dp_eff[idx];
    assign blank_cur = blank_mask[idx];
    assign show      = en && (phase == PH_ON) && (!blank_cur || dp_cur);

    always_comb begin
        seg_ah = blank_cur ? SEG_DP_ONLY : (seg7_decode(nib) | {dp_cur, 7'b0});
        seg_leds_d = SEG_POL;
        seg_ncs_d  = '1;
        if (show) begin
            seg_leds_d = seg_ah ^ SEG_POL;
            seg_ncs_d  = ~(DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            number_q      <= '0;
            dp_q          <= '0;
            lzs_q         <= 1'b0;
            bright_q      <= '0;
            seg_leds_q    <= SEG_POL;
            seg_ncs_q     <= '1;
            frame_start_q <= 1'b0;
        end else begin
            if (snap) begin
                number_q <= number;
                dp_q     <= dp;
                lzs_q    <= lzs;
                bright_q <= brightness;
            end
            seg_leds_q    <= seg_leds_d;
            seg_ncs_q     <= seg_ncs_d;
            frame_start_q <= snap;
        end
    end

    assign seg_leds    = seg_leds_q;
    assign seg_nCS     = seg_ncs_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a position-based reference model scores every cycle,
// while per-feature tasks check the documented scan, brightness, lzs, reset and enable cases.
module tb_seg_scan_mux;

    localparam int D   = 6;
    localparam int SD  = 64;
    localparam int BL  = 16;
    localparam int W   = (SD - BL) / 16;
    localparam int PER = D * SD;

    logic           clk = 1'b0;
    logic           rst;
    logic [4*D-1:0] number;
    logic [D-1:0]   dp;
    logic           lzs;
    logic [3:0]     brightness;
    logic           en;
    logic [7:0]     seg_leds;
    logic [D-1:0]   seg_nCS;
    logic           frame_start;

    int total = 0;
    int bad   = 0;

    logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seg_scan_mux #(
        .DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BL), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .number(number), .dp(dp), .lzs(lzs),
        .brightness(brightness), .en(en), .seg_leds(seg_leds),
        .seg_nCS(seg_nCS), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Reference: outputs depend only on the frame position since reset and the frame snapshot.
    int          k = 0;
    int          pos, slot, off, nibv, m_b;
    logic [63:0] m_num, upper;
    logic [15:0] m_dp;
    logic        m_lzs, blanked, lit;
    logic [7:0]  seg_hi;
    logic [7:0]  exp_seg = 8'hFF;
    logic [D-1:0] exp_ncs = '1;
    logic        exp_fs = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; m_num = '0; m_dp = '0; m_lzs = 1'b0; m_b = 0;
            exp_seg = 8'hFF; exp_ncs = '1; exp_fs = 1'b0;
        end else begin
            pos = k % PER;
            if (pos == 0) begin
                m_num = 64'(number); m_dp = 16'(dp); m_lzs = lzs; m_b = int'(brightness);
            end
            slot    = pos / SD;
            off     = pos % SD;
            upper   = m_num >> (4 * slot);
            nibv    = int'(upper[3:0]);
            blanked = m_lzs && (slot != 0) && (upper == 64'd0);
            lit     = en && (off >= BL) && ((off - BL) < (m_b + 1) * W) && (!blanked || m_dp[slot]);
            exp_ncs = '1;
            seg_hi  = 8'h00;
            if (lit) begin
                exp_ncs[slot] = 1'b0;
                seg_hi = blanked ? 8'h80 : (tbl[nibv] | (m_dp[slot] ? 8'h80 : 8'h00));
            end
            exp_seg = ~seg_hi;
            exp_fs  = (pos == 0);
            k++;
        end
    end

    int meas_low   [D];
    int meas_first [D];
    logic [7:0] meas_seg [D];

    task automatic wait_frame();
        bit found = 0;
        for (int i = 0; i < PER + 4; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_frame: frame_start not seen within %0d cycles", PER + 4);
        end
    endtask

    // Called at the negedge showing frame_start; samples the whole frame.
    task automatic measure_frame();
        for (int i = 0; i < D; i++) begin
            meas_low[i] = 0; meas_first[i] = -1; meas_seg[i] = 8'h00;
        end
        for (int c = 0; c < PER; c++) begin
            int s, o;
            if (c > 0) @(negedge clk);
            s = c / SD;
            o = c % SD;
            if (seg_nCS[s] === 1'b0) begin
                meas_low[s]++;
                if (meas_first[s] < 0) begin
                    meas_first[s] = o;
                    meas_seg[s]   = seg_leds;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; number = 24'h123456; dp = '0; lzs = 1'b0; brightness = 4'd15; en = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (seg_leds !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h want ff", seg_leds); end
        total++;
        if (seg_nCS !== '1) begin bad++; $display("FAIL reset_ncs: got %b want all ones", seg_nCS); end
        total++;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", frame_start); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL first_fs: got %b want 1", frame_start); end
        total++;
        if (seg_nCS !== '1) begin bad++; $display("FAIL first_blank: got %b want all ones", seg_nCS); end
    endtask

    task automatic test_full_brightness();
        measure_frame();
        for (int i = 0; i < D; i++) begin
            int nv = ((24'h123456 >> (4 * i)) & 15);
            total++;
            if (meas_low[i] != 48 || meas_first[i] != BL) begin
                bad++;
                $display("FAIL full_on d%0d: low=%0d first=%0d want low=48 first=%0d", i, meas_low[i], meas_first[i], BL);
            end
            total++;
            if (meas_seg[i] !== ~tbl[nv]) begin
                bad++;
                $display("FAIL full_seg d%0d: got %h want %h", i, meas_seg[i], ~tbl[nv]);
            end
        end
        total++;
        if (meas_seg[0] !== 8'h82 || meas_seg[5] !== 8'hF9) begin
            bad++;
            $display("FAIL full_ends: d0=%h d5=%h want 82 f9", meas_seg[0], meas_seg[5]);
        end
    endtask

    task automatic test_brightness();
        int lv [2] = '{0, 7};
        int want [2] = '{3, 24};
        for (int j = 0; j < 2; j++) begin
            brightness = 4'(lv[j]);
            wait_frame();
            measure_frame();
            for (int i = 0; i < D; i++) begin
                total++;
                if (meas_low[i] != want[j] || meas_first[i] != BL) begin
                    bad++;
                    $display("FAIL bright%0d d%0d: low=%0d first=%0d want low=%0d first=%0d",
                             lv[j], i, meas_low[i], meas_first[i], want[j], BL);
                end
            end
        end
    endtask

    task automatic test_lzs();
        brightness = 4'd15; number = 24'h000042; dp = 6'b000100; lzs = 1'b1;
        wait_frame();
        measure_frame();
        total++;
        if (meas_low[5] != 0 || meas_low[4] != 0 || meas_low[3] != 0) begin
            bad++;
            $display("FAIL lzs_dark: low5=%0d low4=%0d low3=%0d want 0", meas_low[5], meas_low[4], meas_low[3]);
        end
        total++;
        if (meas_low[2] != 48 || meas_seg[2] !== 8'h7F) begin
            bad++;
            $display("FAIL lzs_dp: low=%0d seg=%h want 48 7f", meas_low[2], meas_seg[2]);
        end
        total++;
        if (meas_seg[1] !== 8'h99 || meas_seg[0] !== 8'hA4) begin
            bad++;
            $display("FAIL lzs_digits: d1=%h d0=%h want 99 a4", meas_seg[1], meas_seg[0]);
        end
        lzs = 1'b0; dp = '0;
    endtask

    task automatic test_midframe_change();
        number = 24'h987654;
        wait_frame();
        repeat (50) @(negedge clk);
        number = 24'h0F0F0F;
        repeat (3 * SD + 20 - 50) @(negedge clk);
        total++;
        if (seg_nCS !== 6'b110111 || seg_leds !== 8'hF8) begin
            bad++;
            $display("FAIL midframe_old: ncs=%b seg=%h want 110111 f8", seg_nCS, seg_leds);
        end
        wait_frame();
        repeat (3 * SD + 20) @(negedge clk);
        total++;
        if (seg_nCS !== 6'b110111 || seg_leds !== 8'hC0) begin
            bad++;
            $display("FAIL midframe_new: ncs=%b seg=%h want 110111 c0", seg_nCS, seg_leds);
        end
    endtask

    task automatic test_reset_mid_on();
        wait_frame();
        repeat (20) @(negedge clk);
        total++;
        if (seg_nCS !== 6'b111110) begin bad++; $display("FAIL pre_reset_on: ncs=%b want 111110", seg_nCS); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (seg_nCS !== '1 || seg_leds !== 8'hFF) begin
            bad++;
            $display("FAIL async_reset: ncs=%b seg=%h want all ones ff", seg_nCS, seg_leds);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_fs: got %b want 1", frame_start); end
    endtask

    task automatic test_enable();
        int dark_bad = 0;
        int n = 0;
        wait_frame();
        repeat (30) @(negedge clk);
        en = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (seg_nCS !== '1 || seg_leds !== 8'hFF) dark_bad++;
        end
        total++;
        if (dark_bad != 0) begin bad++; $display("FAIL en_dark: lit cycles=%0d want 0", dark_bad); end
        en = 1'b1;
        for (int i = 0; i < PER + 4; i++) begin
            @(negedge clk);
            n++;
            if (frame_start === 1'b1) break;
        end
        total++;
        if (n != PER - 130) begin bad++; $display("FAIL en_resume: frame_start after %0d want %0d", n, PER - 130); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            int keep = $urandom_range(0, D);
            logic [31:0] r = $urandom;
            number     = 24'(r) & 24'((64'd1 << (4 * keep)) - 1);
            dp         = 6'($urandom);
            lzs        = 1'($urandom);
            brightness = 4'($urandom);
            en         = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, PER)) @(negedge clk);
        end
        en = 1'b1;
        wait_frame();
        repeat (PER) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    total++;
                    if (seg_leds !== exp_seg || seg_nCS !== exp_ncs || frame_start !== exp_fs) begin
                        bad++;
                        $display("FAIL model t=%0t: seg=%h ncs=%b fs=%b want seg=%h ncs=%b fs=%b",
                                 $time, seg_leds, seg_nCS, frame_start, exp_seg, exp_ncs, exp_fs);
                    end
                end
                total++;
                if ($countones(~seg_nCS) > 1) begin
                    bad++;
                    $display("FAIL onehot t=%0t: ncs=%b want at most one low", $time, seg_nCS);
                end
            end
        join_none
        test_reset();
        test_full_brightness();
        test_brightness();
        test_lzs();
        test_midframe_change();
        test_reset_mid_on();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed 7-segment display driver: scans DIGITS common-cathode/anode digits, decodes each 4-bit nibble to a segment pattern, and adds per-slot anti-ghost blanking, 16-level brightness PWM, per-digit decimal points and leading-zero suppression. It sits between the numeric datapath and the board's segment/digit-select pins, replacing the fixed 6-digit scanner. Display inputs are snapshotted once per frame, so a value never tears mid-scan.

## Interface
- DIGITS, 6: number of digits, 1..16.
- SCAN_DIV, 64: clk cycles per digit slot.
- BLANK_CYC, 16: leading cycles of each slot with all digits off; must satisfy (SCAN_DIV-BLANK_CYC) % 16 == 0 and SCAN_DIV > BLANK_CYC.
- SEG_ACTIVE_LOW, 1: 1 inverts seg_leds at the pin.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- number  in  4*DIGITS  nibble i = number[4i+3:4i] drives digit i.
- dp  in  DIGITS  decimal point request per digit.
- lzs  in  1  leading-zero suppression enable.
- brightness  in  4  on-time level; 0 = 1/16 of window, 15 = full window.
- en  in  1  0 = display dark (scan continues).
- seg_leds  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- seg_nCS  out  DIGITS  active-low digit select; bit i = digit i.
- frame_start  out  1  one-cycle pulse when the snapshot is taken.

## Operation
- Counters: cnt 0..SCAN_DIV-1, idx 0..DIGITS-1; cnt wraps → idx increments; idx wraps DIGITS-1 → 0.
- Snapshot: at cnt==0 && idx==0, register number, dp, lzs, brightness; frame_start pulses that cycle. en is not snapshotted (takes effect immediately).
- Slot phases (state derived from cnt): BLANK for cnt < BLANK_CYC; ON for (cnt-BLANK_CYC) < (brightness_s+1)*W, W=(SCAN_DIV-BLANK_CYC)/16; OFF for the remainder of the slot.
- In ON: seg_nCS has only bit idx low; seg_leds = decode(nibble idx) with dp bit = dp_s[idx]. In BLANK/OFF, or en=0: seg_nCS all ones, seg_leds all segments off.
- Leading-zero suppression (lzs_s=1): digit i is blanked (nCS high for its whole slot) if nibbles i..DIGITS-1 are all zero and i != 0; digit 0 is always shown. A blanked digit with dp_s[i]=1 is still enabled, showing the dp segment only.
- Decode 0-F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (active-high, bit7 = dp).
- Digit change always passes through BLANK (≥ BLANK_CYC cycles) when BLANK_CYC>0; no two nCS bits are ever low simultaneously.

## Timing
- All outputs registered; outputs reflect the counter state of the previous cycle (1-cycle latency).
- Reset (async assert): cnt=0, idx=0, snapshot regs 0, seg_nCS all ones, seg_leds off (8'hFF if SEG_ACTIVE_LOW else 8'h00), frame_start 0. Reset mid-slot forces outputs off immediately.
- First edge after rst deassert: cnt=0, idx=0 → snapshot taken, frame_start=1 on the following cycle.
- Frame period = DIGITS*SCAN_DIV cycles; input changes become visible at the next frame boundary only.
- en deassert: outputs off one cycle later; counters unaffected.

## Structure
- Package seg_scan_pkg: the 16-entry segment constant table and function seg7_decode; polarity localparams.
- One sub-module: seg_scan_timer (cnt/idx counters, phase and snapshot strobe). Decode, lzs mask and output registers live in the top.

## Test plan
- DIGITS=6, SCAN_DIV=64, BLANK_CYC=16, brightness=15, number=24'h123456 → digit 0 shows 0x7D ('6') ... digit 5 shows 0x06 ('1'); each nCS low for exactly 48 cycles, preceded by 16 all-high cycles.
- brightness=0 → each digit on for exactly 3 cycles per slot; brightness=7 → 24 cycles.
- lzs=1, number=24'h000042, dp=6'b000100 → digits 5,4,3 dark; digit 2 shows dp only (0x80); digits 1,0 show 0x66, 0x5B.
- Change number mid-frame → displayed value unchanged until after the next frame_start; never two nCS bits low at once (assertion over full run).
- Assert rst during an ON phase → seg_nCS all ones and seg_leds 8'hFF in the same cycle; after release, scan restarts at digit 0 with frame_start.
- en=0 for 100 cycles mid-frame → outputs dark; on en=1, scan resumes at the current counter position with no frame restart.
